// File: rtl/adc_idelay_cal_if.sv
// Control, ADC sample and IDELAYE2 tap-load signals shared by the calibrator (master)
// and the ADC front end that it tunes (slave).
interface adc_idelay_cal_if;
    logic        start;
    logic        idelayctrl_rdy;
    logic [15:0] adc_data;
    logic [7:0]  idelay_ld;
    logic [39:0] idelay_cntvalue;
    logic        busy;
    logic        done;
    logic [7:0]  lane_err;

    modport master (
        input  start, idelayctrl_rdy, adc_data,
        output idelay_ld, idelay_cntvalue, busy, done, lane_err
    );

    modport slave (
        output start, idelayctrl_rdy, adc_data,
        input  idelay_ld, idelay_cntvalue, busy, done, lane_err
    );
endinterface

// File: rtl/adc_idelay_cal.sv
// 8-lane IDELAYE2 eye-scan calibrator: sweeps all 32 taps per lane against a fixed test pattern
// and loads the centre of the widest passing window. `ADC_IDELAY_CAL_MIN_WINDOW_EN rejects narrow windows.
module adc_idelay_cal #(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned COMPARE_SAMPLES = 256,
    parameter logic [15:0] TEST_PATTERN    = 16'hA55A,
    parameter int unsigned MIN_WINDOW      = 4
) (
    input logic              clk,
    input logic              rst,
    adc_idelay_cal_if.master cal
);
`ifdef ADC_IDELAY_CAL_MIN_WINDOW_EN
    localparam bit WIN_CHECK = 1'b1;
`else
    localparam bit WIN_CHECK = 1'b0;
`endif
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int MCW = (COMPARE_SAMPLES > 1) ? $clog2(COMPARE_SAMPLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [MCW-1:0] MATCH_LAST  = MCW'(COMPARE_SAMPLES - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, LOAD, SETTLE, COMPARE, NEXT_TAP, EVAL, APPLY, NEXT_LANE, FINISH
    } state_t;

    state_t         state;
    logic [2:0]     lane;
    logic [4:0]     tap;
    logic [SCW-1:0] settle_cnt;
    logic [MCW-1:0] match_cnt;
    logic [31:0]    eye_map;
    logic [4:0]     scan_idx;
    logic [4:0]     run_start;
    logic [5:0]     run_len;
    logic [4:0]     best_start;
    logic [5:0]     best_len;

    logic [5:0]     run_len_nx;
    logic [4:0]     run_start_nx;
    logic [4:0]     center;
    logic           win_ok;
    logic           lane_match;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        run_len_nx   = '0;
        run_start_nx = run_start;
        if (eye_map[scan_idx]) begin
            run_len_nx = run_len + 6'd1;
            if (run_len == 6'd0) run_start_nx = scan_idx;
        end
        center     = best_start + 5'((best_len - 6'd1) >> 1);
        win_ok     = (best_len != 6'd0) && (!WIN_CHECK || 32'(best_len) >= MIN_WINDOW);
        lane_match = cal.adc_data[{lane, 1'b0} +: 2] == TEST_PATTERN[{lane, 1'b0} +: 2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            lane                <= '0;
            tap                 <= '0;
            settle_cnt          <= '0;
            match_cnt           <= '0;
            // NOTE: eye_map is a few flops rather than a RAM, so reset clears it like any other state.
            eye_map             <= '0;
            scan_idx            <= '0;
            run_start           <= '0;
            run_len             <= '0;
            best_start          <= '0;
            best_len            <= '0;
            cal.idelay_ld       <= '0;
            cal.idelay_cntvalue <= '0;
            cal.busy            <= 1'b0;
            cal.done            <= 1'b0;
            cal.lane_err        <= '0;
        end else begin
            // NOTE: state only ever takes <=, so every branch below reads pre-edge values.
            cal.idelay_ld <= '0;
            cal.done      <= 1'b0;
            if (state != IDLE && state != WAIT_RDY && !cal.idelayctrl_rdy) begin
                state <= WAIT_RDY;
            end else begin
                case (state)
                    IDLE: if (cal.start) begin
                        cal.busy <= 1'b1;
                        state    <= WAIT_RDY;
                    end
                    WAIT_RDY: if (cal.idelayctrl_rdy) begin
                        cal.lane_err <= '0;
                        lane         <= '0;
                        tap          <= '0;
                        state        <= LOAD;
                    end
                    LOAD: begin
                        cal.idelay_cntvalue[int'(lane) * 5 +: 5] <= tap;
                        cal.idelay_ld[lane] <= 1'b1;
                        settle_cnt          <= '0;
                        state               <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            match_cnt <= '0;
                            state     <= COMPARE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    COMPARE: begin
                        if (!lane_match) begin
                            eye_map[tap] <= 1'b0;
                            state        <= NEXT_TAP;
                        end else if (match_cnt == MATCH_LAST) begin
                            eye_map[tap] <= 1'b1;
                            state        <= NEXT_TAP;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    NEXT_TAP: begin
                        if (tap == 5'd31) begin
                            scan_idx   <= '0;
                            run_start  <= '0;
                            run_len    <= '0;
                            best_start <= '0;
                            best_len   <= '0;
                            state      <= EVAL;
                        end else begin
                            tap   <= tap + 5'd1;
                            state <= LOAD;
                        end
                    end
                    EVAL: begin
                        run_len   <= run_len_nx;
                        run_start <= run_start_nx;
                        // Strictly longer only, so the earliest window wins a tie.
                        if (run_len_nx > best_len) begin
                            best_len   <= run_len_nx;
                            best_start <= run_start_nx;
                        end
                        if (scan_idx == 5'd31) state <= APPLY;
                        else scan_idx <= scan_idx + 5'd1;
                    end
                    APPLY: begin
                        if (win_ok) begin
                            cal.idelay_cntvalue[int'(lane) * 5 +: 5] <= center;
                        end else begin
                            cal.idelay_cntvalue[int'(lane) * 5 +: 5] <= 5'd0;
                            cal.lane_err[lane] <= 1'b1;
                        end
                        cal.idelay_ld[lane] <= 1'b1;
                        state               <= NEXT_LANE;
                    end
                    NEXT_LANE: begin
                        if (lane == 3'd7) begin
                            state <= FINISH;
                        end else begin
                            lane  <= lane + 3'd1;
                            tap   <= '0;
                            state <= LOAD;
                        end
                    end
                    FINISH: begin
                        cal.done <= 1'b1;
                        cal.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_idelay_cal.sv
// Self-checking bench for adc_idelay_cal: a per-lane IDELAY/ADC model answers each tap load,
// and a longest-window reference predicts the final taps and lane_err.
module tb_adc_idelay_cal;
    localparam int          S      = 4;
    localparam int          N      = 8;
    localparam int          MINW   = 4;
    localparam logic [15:0] PAT    = 16'hA55A;
    localparam int          BUDGET = 12000;

    typedef struct packed {
        logic [4:0] tap;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    adc_idelay_cal_if bus ();

    adc_idelay_cal #(
        .SETTLE_CYCLES   (S),
        .COMPARE_SAMPLES (N),
        .TEST_PATTERN    (PAT),
        .MIN_WINDOW      (MINW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cal (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_mis;
    int          done_cnt;
    logic [7:0]  prev_ld;
    logic [31:0] pass_map [8];   // tap always returns the pattern
    logic [31:0] late_map [8];   // pattern for exactly N compared words, then breaks
    logic [31:0] marg_map [8];   // pattern for only N-1 compared words
    logic [4:0]  cur_tap  [8];
    int          age      [8];   // cycles since the lane's last load strobe
    logic [4:0]  exp_tap  [8];
    logic [7:0]  exp_err;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, advance the front-end model, drive data.
    task automatic step();
        logic [1:0]  want;
        logic [15:0] d;
        @(posedge clk);
        #1;
        if (bus.idelay_ld != '0 || prev_ld != '0) begin
            check("ld_onehot", 40'($onehot0(bus.idelay_ld)), 40'd1);
            check("ld_back_to_back", 40'(bus.idelay_ld != '0 && prev_ld != '0), 40'd0);
        end
        prev_ld = bus.idelay_ld;
        if (bus.done) done_cnt++;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus.idelay_ld[i]) begin
                cur_tap[i] = bus.idelay_cntvalue[5*i +: 5];
                age[i]     = 0;
            end else if (age[i] < 100000) begin
                age[i]++;
            end
            want = PAT[2*i +: 2];
            if (pass_map[i][cur_tap[i]])      d[2*i +: 2] = want;
            else if (late_map[i][cur_tap[i]]) d[2*i +: 2] = (age[i] < S + N) ? want : ~want;
            else if (marg_map[i][cur_tap[i]]) d[2*i +: 2] = (age[i] < S + N - 1) ? want : ~want;
            else                              d[2*i +: 2] = want ^ 2'($urandom_range(1, 3));
        end
        bus.adc_data = d;
    endtask

    function automatic exp_t ref_lane(input logic [31:0] eye);
        exp_t r;
        int   best_len = 0;
        int   best_start = 0;
        bit   ok;
        for (int s = 0; s < 32; s++) begin
            int l = 0;
            while (s + l < 32 && eye[s + l]) l++;
            if (l > best_len) begin
                best_len   = l;
                best_start = s;
            end
        end
        ok = best_len > 0;
`ifdef ADC_IDELAY_CAL_MIN_WINDOW_EN
        ok = ok && best_len >= MINW;
`endif
        r.tap = ok ? 5'(best_start + (best_len - 1) / 2) : 5'd0;
        r.err = !ok;
        return r;
    endfunction

    task automatic clear_maps();
        for (int i = 0; i < 8; i++) begin
            pass_map[i] = '0;
            late_map[i] = '0;
            marg_map[i] = '0;
        end
    endtask

    task automatic set_pass(input int lane, input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pass_map[lane][t] = 1'b1;
    endtask

    task automatic nominal_maps();
        clear_maps();
        set_pass(0, 10, 19);
        for (int i = 1; i < 8; i++) set_pass(i, 4, 7);
    endtask

    task automatic compute_expected();
        exp_t r;
        for (int i = 0; i < 8; i++) begin
            r          = ref_lane(pass_map[i] | late_map[i]);
            exp_tap[i] = r.tap;
            exp_err[i] = r.err;
        end
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_lane%0d_tap", tag, i),
                  40'(bus.idelay_cntvalue[5*i +: 5]), 40'(exp_tap[i]));
        check($sformatf("%s_lane_err", tag), 40'(bus.lane_err), 40'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ld"}, 40'(bus.idelay_ld), 40'd0);
        check({tag, "_cntvalue"}, bus.idelay_cntvalue, 40'd0);
        check({tag, "_busy"}, 40'(bus.busy), 40'd0);
        check({tag, "_done"}, 40'(bus.done), 40'd0);
        check({tag, "_lane_err"}, 40'(bus.lane_err), 40'd0);
    endtask

    // Full calibration; optional extra start pulse at cycle pulse_at, optional rdy drop in lane 4.
    task automatic run_cal(input string tag, input int pulse_at, input bit drop_lane4);
        int cyc     = 0;
        int d0      = done_cnt;
        bit got     = 0;
        bit dropped = 0;
        compute_expected();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({tag, "_busy_after_start"}, 40'(bus.busy), 40'd1);
        while (!got && cyc < BUDGET) begin
            step();
            cyc++;
            bus.start = (cyc == pulse_at);
            if (drop_lane4 && !dropped && bus.idelay_ld[4]) begin
                dropped = 1;
                bus.idelayctrl_rdy = 1'b0;
                repeat (6) step();
                cyc += 6;
                check({tag, "_abort_busy"}, 40'(bus.busy), 40'd1);
                check({tag, "_abort_no_ld"}, 40'(bus.idelay_ld), 40'd0);
                bus.idelayctrl_rdy = 1'b1;
                while (bus.idelay_ld == '0 && cyc < BUDGET) begin
                    step();
                    cyc++;
                end
                check({tag, "_restart_lane"}, 40'(bus.idelay_ld), 40'd1);
                check({tag, "_restart_tap"}, 40'(bus.idelay_cntvalue[4:0]), 40'd0);
            end
            if (bus.done) begin
                got = 1;
                check({tag, "_busy_at_done"}, 40'(bus.busy), 40'd0);
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 40'(got), 40'd1);
        if (drop_lane4) check({tag, "_drop_happened"}, 40'(dropped), 40'd1);
        repeat (10) step();
        check({tag, "_done_pulses"}, 40'(done_cnt - d0), 40'd1);
        check_results(tag);
    endtask

    initial begin
        int cyc;
        int d0;
        bit seen;
        n_cmp    = 0;
        n_mis    = 0;
        done_cnt = 0;
        prev_ld  = '0;
        rst      = 1'b1;
        bus.start          = 1'b0;
        bus.idelayctrl_rdy = 1'b1;
        bus.adc_data       = '0;
        clear_maps();
        for (int i = 0; i < 8; i++) begin
            cur_tap[i] = '0;
            age[i]     = 100000;
        end

        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) step();
        check("idle_busy", 40'(bus.busy), 40'd0);

        // lane 0 window 10..19 -> 14, others 4..7 -> 5
        nominal_maps();
        run_cal("nominal", -1, 1'b0);
        check("nominal_lane0_is_14", 40'(bus.idelay_cntvalue[4:0]), 40'd14);
        check("nominal_lane1_is_5", 40'(bus.idelay_cntvalue[9:5]), 40'd5);
        repeat (40) step();
        check_results("hold");

        // lane 3 dead, with a start pulse while busy
        nominal_maps();
        pass_map[3] = '0;
        run_cal("lane3_dead", 700, 1'b0);
        check("lane3_dead_err", 40'(bus.lane_err), 40'h08);

        // tied windows on lane 2, single-tap window at 31 on lane 1
        nominal_maps();
        pass_map[2] = '0;
        set_pass(2, 2, 4);
        set_pass(2, 20, 22);
        pass_map[1] = '0;
        set_pass(1, 31, 31);
        run_cal("tie", -1, 1'b0);
        check("tie_lane2_is_3", 40'(bus.idelay_cntvalue[14:10]), 40'd3);

        // narrow window 8..9 on lane 5
        nominal_maps();
        pass_map[5] = '0;
        set_pass(5, 8, 9);
        run_cal("narrow", -1, 1'b0);

        // idelayctrl_rdy drop during lane 4
        nominal_maps();
        run_cal("rdy_drop", -1, 1'b1);

        // random eyes including taps that fail on the last compared word or just after it
        for (int r = 0; r < 3; r++) begin
            clear_maps();
            for (int i = 0; i < 8; i++) begin
                for (int t = 0; t < 32; t++) begin
                    int k = $urandom_range(0, 9);
                    if (k < 4)       pass_map[i][t] = 1'b1;
                    else if (k == 4) late_map[i][t] = 1'b1;
                    else if (k == 5) marg_map[i][t] = 1'b1;
                end
                if ($urandom_range(0, 7) == 0) begin
                    pass_map[i] = '0;
                    late_map[i] = '0;
                end
            end
            run_cal($sformatf("rand%0d", r), -1, 1'b0);
        end

        // reset in the middle of lane 6
        nominal_maps();
        d0 = done_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < BUDGET) begin
            step();
            cyc++;
            if (bus.idelay_ld[6]) seen = 1;
        end
        check("rst_reach_lane6", 40'(seen), 40'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        step();
        step();
        rst = 1'b0;
        repeat (60) step();
        check("rst_no_done", 40'(done_cnt - d0), 40'd0);
        check("rst_stays_idle", 40'(bus.busy), 40'd0);
        check("rst_outputs_held", bus.idelay_cntvalue, 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
